// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Word-wide data-memory target for the datapath's dmem port. A request is
//   accepted in IDLE, held for WAIT_CYCLES wait states, then performed against
//   an internal 2^ADDR_WIDTH x 32 array. Completion is signalled by a one-cycle
//   ready pulse carrying registered rdata and an err flag. Misaligned or
//   out-of-range byte addresses complete with err=1 and leave memory untouched.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for req; request fields are latched on acceptance
//   WAIT  | counting down wait states; access performed when cnt reaches 1
//   DONE  | ready=1 for this single cycle, rdata/err valid; returns to IDLE
//
// Ports
//   clk    in   clock, rising-edge
//   rst    in   synchronous reset, active low
//   req    in   access request, sampled only in IDLE
//   we     in   1 = store word, 0 = load word
//   addr   in   [31:0] byte address
//   wdata  in   [31:0] store data
//   rdata  out  [31:0] response data, held until the next completion
//   ready  out  one-cycle completion pulse
//   err    out  rejected access, valid only with ready
//   busy   out  high in WAIT and DONE
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int        DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic                    bad_q, bad_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [31:0]             mem_q [DEPTH];

    logic                    accept;
    logic                    do_access;
    logic                    in_bad;
    logic [ADDR_WIDTH-1:0]   in_idx;
    logic                    acc_we;
    logic                    acc_bad;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             acc_wdata;
    logic                    mem_we;

    // State register and datapath flops. Latched request fields need no reset:
    // they are only consumed after a fresh acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
        we_q    <= we_d;
        bad_q   <= bad_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    // Array is never cleared; reset suppresses the write on the edge where it
    // is asserted so an aborted store cannot land.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = S_DONE;
                        do_access = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d   = S_DONE;
                    cnt_d     = 4'd0;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Request classification and access datapath. With zero wait states the
    // access happens on the accept edge, so the live inputs are used in IDLE
    // and the latched copies everywhere else.
    always_comb begin
        in_idx = addr[ADDR_WIDTH+1:2];
        in_bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_WIDTH + 2)) != 32'd0);

        we_d    = we_q;
        bad_d   = bad_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        if (accept) begin
            we_d    = we;
            bad_d   = in_bad;
            idx_d   = in_idx;
            wdata_d = wdata;
        end

        if (state_q == S_IDLE) begin
            acc_we    = we;
            acc_bad   = in_bad;
            acc_idx   = in_idx;
            acc_wdata = wdata;
        end else begin
            acc_we    = we_q;
            acc_bad   = bad_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
        end

        mem_we  = do_access && acc_we && !acc_bad;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        if (do_access) begin
            err_d = acc_bad;
            if (acc_bad) begin
                rdata_d = 32'd0;
            end else if (acc_we) begin
                rdata_d = acc_wdata;
            end else begin
                rdata_d = mem_q[acc_idx];
            end
        end
    end

    // Outputs depend on registered state only.
    always_comb begin
        ready = (state_q == S_DONE);
        busy  = (state_q != S_IDLE);
        rdata = rdata_q;
        err   = err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic        req0, we0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, err0, busy0;

    logic        req1, we1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        ready1, err1, busy1;

    int checks;
    int errors;

    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
    );

    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Access on the W=2 instance; lat counts negedges after the accept edge
    // until ready is seen (W+1 expected), 0 means it never came.
    task automatic acc0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat,
                        output logic rdy_after);
        rd = 32'd0; e = 1'b0; lat = 0; rdy_after = 1'b1;
        @(negedge clk);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        @(posedge clk);
        #1;
        req0 = 1'b0; we0 = ~w; addr0 = 32'h0000_0024; wdata0 = 32'hBAD0_BAD0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready0) begin
                rd = rdata0; e = err0; lat = i;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            rdy_after = ready0;
        end
    endtask

    task automatic acc1(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat,
                        output logic rdy_after);
        rd = 32'd0; e = 1'b0; lat = 0; rdy_after = 1'b1;
        @(negedge clk);
        req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        @(posedge clk);
        #1;
        req1 = 1'b0; we1 = ~w; addr1 = 32'h0000_0024; wdata1 = 32'hBAD0_BAD0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready1) begin
                rd = rdata1; e = err1; lat = i;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            rdy_after = ready1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b want 0", ready0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b want 0", busy0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0 got %b want 0", err0); end
        checks++; if (rdata0 !== 32'd0) begin errors++; $display("FAIL reset_rdata0 got %h want 0", rdata0); end
        checks++; if (ready1 !== 1'b0 || busy1 !== 1'b0 || err1 !== 1'b0) begin
            errors++; $display("FAIL reset_flags1 got r%b b%b e%b want 0 0 0", ready1, busy1, err1);
        end
        checks++; if (rdata1 !== 32'd0) begin errors++; $display("FAIL reset_rdata1 got %h want 0", rdata1); end
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic e; int lat; logic ra;
        acc0(1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_echo got %h want deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", e); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL wr_pulse_width ready stayed %b want 0", ra); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL wr_busy_after got %b want 0", busy0); end
        acc0(1'b0, 32'h10, 32'h0, rd, e, lat, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", e); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic e; int lat; logic ra;
        acc1(1'b1, 32'h3FC, 32'h12345678, rd, e, lat, ra);
        checks++; if (lat !== 1) begin errors++; $display("FAIL zw_wr_latency got %0d want 1", lat); end
        checks++; if (rd !== 32'h12345678 || e !== 1'b0) begin
            errors++; $display("FAIL zw_wr_resp got %h/%b want 12345678/0", rd, e);
        end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL zw_pulse_width ready stayed %b want 0", ra); end
        acc1(1'b0, 32'h3FC, 32'h0, rd, e, lat, ra);
        checks++; if (lat !== 1) begin errors++; $display("FAIL zw_rd_latency got %0d want 1", lat); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL zw_rd_data got %h want 12345678", rd); end
        acc1(1'b0, 32'h3FD, 32'h0, rd, e, lat, ra);
        checks++; if (e !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("FAIL zw_misaligned got %h/%b want 0/1", rd, e);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic e; int lat; logic ra;
        acc0(1'b1, 32'h12, 32'hFFFF0000, rd, e, lat, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mis_latency got %0d want 3", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL mis_err got %b want 1", e); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL mis_rdata got %h want 0", rd); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL mis_err_clears got %b want 0", err0); end
        acc0(1'b0, 32'h10, 32'h0, rd, e, lat, ra);
        checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++; $display("FAIL mis_mem_intact got %h/%b want deadbeef/0", rd, e);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic e; int lat; logic ra;
        acc0(1'b0, 32'h400, 32'h0, rd, e, lat, ra);
        checks++; if (e !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("FAIL oor_400 got %h/%b want 0/1", rd, e);
        end
        acc0(1'b1, 32'h8000_0010, 32'h55555555, rd, e, lat, ra);
        checks++; if (e !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("FAIL oor_high_bit got %h/%b want 0/1", rd, e);
        end
        acc0(1'b1, 32'h3FC, 32'hCAFEF00D, rd, e, lat, ra);
        acc0(1'b0, 32'h3FC, 32'h0, rd, e, lat, ra);
        checks++; if (e !== 1'b0 || rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL oor_top_word got %h/%b want cafef00d/0", rd, e);
        end
        acc0(1'b0, 32'h10, 32'h0, rd, e, lat, ra);
        checks++; if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL oor_no_alias got %h want deadbeef", rd);
        end
    endtask

    task automatic test_busy_drop();
        logic [31:0] rd; logic e; int lat; logic ra; int pulses;
        acc0(1'b1, 32'h20, 32'h11111111, rd, e, lat, ra);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = 32'h0;
        @(posedge clk);
        #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h22222222;
        @(negedge clk);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL drop_busy got %b want 1", busy0); end
        @(posedge clk);
        @(posedge clk);
        #1;
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        checks++; if (ready0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || err0 !== 1'b0) begin
            errors++; $display("FAIL drop_orig_resp got r%b %h e%b want 1 deadbeef 0", ready0, rdata0, err0);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL drop_extra_pulses got %0d want 0", pulses); end
        acc0(1'b0, 32'h20, 32'h0, rd, e, lat, ra);
        checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL drop_no_write got %h want 11111111", rd); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ready0) pulses++;
        end
        req0 = 1'b0;
        checks++; if (pulses !== 4) begin errors++; $display("FAIL b2b_pulses got %0d want 4", pulses); end
        repeat (4) @(negedge clk);
        checks++; if (busy0 !== 1'b0 || rdata0 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL b2b_final got b%b %h want 0 deadbeef", busy0, rdata0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic e; int lat; logic ra; int pulses;
        acc0(1'b1, 32'h30, 32'h5A5A5A5A, rd, e, lat, ra);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        req0 = 1'b0; we0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ready0 !== 1'b0 || busy0 !== 1'b0 || err0 !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags got r%b b%b e%b want 0 0 0", ready0, busy0, err0);
        end
        checks++; if (rdata0 !== 32'd0) begin errors++; $display("FAIL rstmid_rdata got %h want 0", rdata0); end
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_pulses got %0d want 0", pulses); end
        acc0(1'b0, 32'h30, 32'h0, rd, e, lat, ra);
        checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL rstmid_mem got %h want 5a5a5a5a", rd); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        test_reset();
        test_write_read();
        test_zero_wait();
        test_misaligned();
        test_out_of_range();
        test_busy_drop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
